// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one 4-lane byte-addressable data RAM (1-cycle synchronous read)
//   between an instruction-fetch port (IF) and a load/store port (LS).
//   At most one request is granted per cycle. Its response is returned
//   exactly one cycle after acceptance. LS has priority. IF is forced a
//   grant after STARVE_MAX consecutive LS grants while IF was waiting.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   if_req_*            IF word read request (valid/ready/addr)
//   if_rsp_*            IF read response (valid/data)
//   ls_req_*            LS request (valid/ready/addr/we/size/uns/wdata)
//   ls_rsp_*            LS response (valid/data/err)
//   ram_*               RAM side: lane write enables, byte address,
//                       lane-positioned write data, read enable, read data
module ram_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_valid,
  output logic          if_req_ready,
  input  logic [AW-1:0] if_req_addr,
  output logic          if_rsp_valid,
  output logic [DW-1:0] if_rsp_data,
  input  logic          ls_req_valid,
  output logic          ls_req_ready,
  input  logic [AW-1:0] ls_req_addr,
  input  logic          ls_req_we,
  input  logic [1:0]    ls_req_size,
  input  logic          ls_req_uns,
  input  logic [DW-1:0] ls_req_wdata,
  output logic          ls_rsp_valid,
  output logic [DW-1:0] ls_rsp_data,
  output logic          ls_rsp_err,
  output logic [3:0]    ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_ren,
  input  logic [DW-1:0] ram_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;
  logic          if_pend_q, if_pend_d;
  logic          ls_pend_q, ls_pend_d;
  logic          ls_load_q, ls_load_d;
  logic          ls_err_q, ls_err_d;
  logic [1:0]    ls_off_q, ls_off_d;
  logic [1:0]    ls_size_q, ls_size_d;
  logic          ls_uns_q, ls_uns_d;

  logic          if_gnt, ls_gnt, ls_bad;
  logic [3:0]    lane_base;
  logic [DW-1:0] store_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [DW-1:0] ld_ext;

  // Grant and starvation tracking. Nothing is granted while in reset so
  // requests presented then are dropped and the RAM stays idle.
  always_comb begin
    if_gnt   = !rst && if_req_valid && (!ls_req_valid || starve_q == STARVE_LIM);
    ls_gnt   = !rst && ls_req_valid && !if_gnt;
    starve_d = starve_q;
    if (if_gnt || !if_req_valid) begin
      starve_d = '0;
    end else if (ls_gnt && starve_q != STARVE_LIM) begin
      starve_d = starve_q + SW'(1);
    end
  end

  assign if_req_ready = if_gnt;
  assign ls_req_ready = ls_gnt;

  // Size/alignment decode and lane placement of store data.
  always_comb begin
    ls_bad     = 1'b0;
    lane_base  = 4'b1111;
    store_data = ls_req_wdata;
    case (ls_req_size)
      2'b00: begin
        lane_base  = 4'b0001;
        store_data = {4{ls_req_wdata[7:0]}};
      end
      2'b01: begin
        lane_base  = 4'b0011;
        store_data = {2{ls_req_wdata[15:0]}};
        ls_bad     = ls_req_addr[0];
      end
      2'b10: begin
        ls_bad = (ls_req_addr[1:0] != 2'b00);
      end
      default: begin
        ls_bad = 1'b1;
      end
    endcase
  end

  always_comb begin
    ram_ren   = 1'b0;
    ram_wen   = 4'b0000;
    ram_addr  = '0;
    ram_wdata = '0;
    if (if_gnt) begin
      ram_ren  = 1'b1;
      ram_addr = if_req_addr;
    end else if (ls_gnt) begin
      ram_addr = ls_req_addr;
      if (!ls_bad) begin
        if (ls_req_we) begin
          ram_wen   = lane_base << ls_req_addr[1:0];
          ram_wdata = store_data;
        end else begin
          ram_ren = 1'b1;
        end
      end
    end
  end

  // Per-request context captured at acceptance for the response cycle.
  always_comb begin
    if_pend_d = if_gnt;
    ls_pend_d = ls_gnt;
    ls_load_d = ls_gnt && !ls_req_we && !ls_bad;
    ls_err_d  = ls_gnt && ls_bad;
    ls_off_d  = ls_req_addr[1:0];
    ls_size_d = ls_req_size;
    ls_uns_d  = ls_req_uns;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q  <= '0;
      if_pend_q <= 1'b0;
      ls_pend_q <= 1'b0;
      ls_load_q <= 1'b0;
      ls_err_q  <= 1'b0;
      ls_off_q  <= 2'b00;
      ls_size_q <= 2'b00;
      ls_uns_q  <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      if_pend_q <= if_pend_d;
      ls_pend_q <= ls_pend_d;
      ls_load_q <= ls_load_d;
      ls_err_q  <= ls_err_d;
      ls_off_q  <= ls_off_d;
      ls_size_q <= ls_size_d;
      ls_uns_q  <= ls_uns_d;
    end
  end

  // Load extraction from the RAM word returned in the response cycle.
  always_comb begin
    ld_byte = ram_rdata[{ls_off_q, 3'b000} +: 8];
    ld_half = ls_off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (ls_size_q)
      2'b00:   ld_ext = ls_uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = ls_uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = ram_rdata;
    endcase
  end

  assign if_rsp_valid = if_pend_q;
  assign if_rsp_data  = if_pend_q ? ram_rdata : '0;
  assign ls_rsp_valid = ls_pend_q;
  assign ls_rsp_err   = ls_pend_q && ls_err_q;
  assign ls_rsp_data  = (ls_pend_q && ls_load_q) ? ld_ext : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Self-checking bench for ram_arbiter. A byte-array golden memory and a
//   request-level model predict grants, RAM drive and responses; a simple
//   word RAM attached to the DUT's RAM port supplies read data.
module tb_ram_arbiter;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        ls_req_valid, ls_req_ready;
  logic [31:0] ls_req_addr;
  logic        ls_req_we;
  logic [1:0]  ls_req_size;
  logic        ls_req_uns;
  logic [31:0] ls_req_wdata;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_data;
  logic        ls_rsp_err;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_ren;
  logic [31:0] ram_rdata;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_req_we(ls_req_we), .ls_req_size(ls_req_size), .ls_req_uns(ls_req_uns),
    .ls_req_wdata(ls_req_wdata), .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .ls_rsp_err(ls_rsp_err), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_ren(ram_ren), .ram_rdata(ram_rdata)
  );

  function automatic logic [7:0] init_byte(int a);
    return 8'((a * 13 + 7) & 255);
  endfunction

  // RAM attached to the DUT (1 KiB, 256 words).
  logic [31:0] ram_mem [0:255];
  logic        ram_init;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++)
        ram_mem[i] <= {init_byte(4*i+3), init_byte(4*i+2), init_byte(4*i+1), init_byte(4*i)};
      ram_rdata <= 32'h0;
    end else begin
      if (ram_ren) ram_rdata <= ram_mem[ram_addr[9:2]];
      for (int k = 0; k < 4; k++)
        if (ram_wen[k]) ram_mem[ram_addr[9:2]][8*k +: 8] <= ram_wdata[8*k +: 8];
    end
  end

  // Reference model state.
  logic [7:0]  gm [0:1023];
  int          streak;
  logic        exp_if_v, exp_ls_v, exp_ls_e;
  logic [31:0] exp_if_d, exp_ls_d;
  int          n_cmp = 0;
  int          n_mis = 0;
  int          obs_gnt;
  logic [3:0]  obs_wen;
  logic [31:0] obs_wdata, obs_ls_data, obs_if_data;
  logic        obs_ren, obs_ls_err, obs_ls_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic logic [31:0] gm_read(logic [31:0] a, int nb, logic uns);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < nb; i++) v = v | (32'(gm[(a + i) & 1023]) << (8 * i));
    if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
    return v;
  endfunction

  // One clock cycle: check responses and RAM drive against the model,
  // then advance the model at the clock edge. Inputs are changed by the
  // caller between calls (1 time unit after the rising edge).
  task automatic cycle();
    logic g_if, g_ls, bad;
    int nb;
    logic [3:0]  e_wen;
    logic [31:0] e_wd;
    logic        e_ren;
    @(negedge clk);
    chk("if_rsp_valid", {31'b0, if_rsp_valid}, {31'b0, exp_if_v});
    chk("if_rsp_data", if_rsp_data, exp_if_v ? exp_if_d : 32'h0);
    chk("ls_rsp_valid", {31'b0, ls_rsp_valid}, {31'b0, exp_ls_v});
    chk("ls_rsp_err", {31'b0, ls_rsp_err}, {31'b0, exp_ls_e});
    chk("ls_rsp_data", ls_rsp_data, exp_ls_v ? exp_ls_d : 32'h0);
    obs_ls_data = ls_rsp_data;
    obs_ls_err  = ls_rsp_err;
    obs_ls_v    = ls_rsp_valid;
    obs_if_data = if_rsp_data;

    g_if = !rst && if_req_valid && (!ls_req_valid || streak >= SMAX);
    g_ls = !rst && ls_req_valid && !g_if;
    chk("if_req_ready", {31'b0, if_req_ready}, {31'b0, g_if});
    chk("ls_req_ready", {31'b0, ls_req_ready}, {31'b0, g_ls});
    obs_gnt = if_req_ready ? 1 : (ls_req_ready ? 2 : 0);

    nb  = (ls_req_size == 2'b11) ? 1 : nbytes(ls_req_size);
    bad = (ls_req_size == 2'b11) || ((ls_req_addr % nb) != 0);
    e_ren = g_if || (g_ls && !ls_req_we && !bad);
    e_wen = 4'b0;
    e_wd  = 32'h0;
    if (g_ls && ls_req_we && !bad) begin
      for (int i = 0; i < nb; i++) e_wen[ls_req_addr[1:0] + i] = 1'b1;
      for (int k = 0; k < 4; k++) e_wd[8*k +: 8] = ls_req_wdata[8*(k % nb) +: 8];
    end
    chk("ram_ren", {31'b0, ram_ren}, {31'b0, e_ren});
    chk("ram_wen", {28'b0, ram_wen}, {28'b0, e_wen});
    if (e_wen != 4'b0) chk("ram_wdata", ram_wdata, e_wd);
    if (e_ren || e_wen != 4'b0) chk("ram_addr", ram_addr, g_if ? if_req_addr : ls_req_addr);
    obs_wen   = ram_wen;
    obs_wdata = ram_wdata;
    obs_ren   = ram_ren;

    exp_if_v = g_if;
    exp_if_d = gm_read(if_req_addr & 32'hFFFF_FFFC, 4, 1'b1);
    exp_ls_v = g_ls;
    exp_ls_e = g_ls && bad;
    exp_ls_d = (g_ls && !ls_req_we && !bad) ? gm_read(ls_req_addr, nb, ls_req_uns) : 32'h0;

    if (rst || g_if || !if_req_valid) streak = 0;
    else if (g_ls && streak < SMAX) streak++;
    if (g_ls && ls_req_we && !bad)
      for (int i = 0; i < nb; i++) gm[(ls_req_addr + i) & 1023] = ls_req_wdata[8*i +: 8];

    @(posedge clk);
    #1;
  endtask

  task automatic drive_ls(input logic v, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] d);
    ls_req_valid = v;
    ls_req_we    = we;
    ls_req_size  = sz;
    ls_req_uns   = uns;
    ls_req_addr  = a;
    ls_req_wdata = d;
  endtask

  task automatic drive_if(input logic v, input logic [31:0] a);
    if_req_valid = v;
    if_req_addr  = a;
  endtask

  initial begin
    logic hold_if, hold_ls;
    int   sz;
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) gm[i] = init_byte(i);
    streak   = 0;
    exp_if_v = 1'b0; exp_ls_v = 1'b0; exp_ls_e = 1'b0;
    exp_if_d = 32'h0; exp_ls_d = 32'h0;
    ram_init = 1'b1;
    rst      = 1'b1;
    drive_if(1'b1, 32'h20);
    drive_ls(1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    ram_init = 1'b0;

    // Reset held with both ports requesting.
    cycle();
    chk("rst_wen", {28'b0, obs_wen}, 32'h0);
    chk("rst_ren", {31'b0, obs_ren}, 32'h0);
    cycle();
    rst = 1'b0;
    drive_if(1'b0, 32'h0);
    drive_ls(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    cycle();
    chk("rst_no_rsp", {31'b0, obs_ls_v}, 32'h0);

    // Byte store / signed and unsigned byte loads.
    drive_ls(1'b1, 1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00A5);
    cycle();
    chk("st_b_wen", {28'b0, obs_wen}, 32'h8);
    chk("st_b_wdata", obs_wdata, 32'hA5A5_A5A5);
    drive_ls(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
    cycle();
    drive_ls(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
    cycle();
    chk("ld_b_s", obs_ls_data, 32'hFFFF_FFA5);
    drive_ls(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    cycle();
    chk("ld_b_u", obs_ls_data, 32'h0000_00A5);

    // Half store / signed half load.
    drive_ls(1'b1, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_8001);
    cycle();
    chk("st_h_wen", {28'b0, obs_wen}, 32'hC);
    drive_ls(1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
    cycle();
    drive_ls(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    cycle();
    chk("ld_h_s", obs_ls_data, 32'hFFFF_8001);

    // Misaligned word and illegal size.
    drive_ls(1'b1, 1'b0, 2'b10, 1'b0, 32'h006, 32'h0);
    cycle();
    chk("mis_ren", {31'b0, obs_ren}, 32'h0);
    drive_ls(1'b1, 1'b0, 2'b11, 1'b0, 32'h000, 32'h0);
    cycle();
    chk("mis_err", {31'b0, obs_ls_err}, 32'h1);
    chk("mis_data", obs_ls_data, 32'h0);
    drive_ls(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    cycle();
    chk("ill_err", {31'b0, obs_ls_err}, 32'h1);

    // Both ports requesting continuously: LS x4 then IF, repeating.
    drive_if(1'b1, 32'h10);
    drive_ls(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 15; i++) begin
      cycle();
      chk("starve_gnt", obs_gnt, (i % 5 == 4) ? 32'd1 : 32'd2);
    end
    drive_if(1'b0, 32'h0);
    drive_ls(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    cycle();

    // IF alone, back to back.
    for (int i = 0; i < 3; i++) begin
      drive_if(1'b1, 32'(4 * i));
      cycle();
      chk("if_b2b_gnt", obs_gnt, 32'd1);
    end
    drive_if(1'b0, 32'h0);
    cycle();
    chk("if_b2b_last", obs_if_data, gm_read(32'h8, 4, 1'b1));

    // Randomized traffic; a request not granted is held until it is.
    for (int n = 0; n < 400; n++) begin
      hold_if = if_req_valid && !if_req_ready;
      hold_ls = ls_req_valid && !ls_req_ready;
      if (!hold_if) drive_if(($urandom_range(0, 99) < 45), 32'($urandom_range(0, 1023)));
      if (!hold_ls) begin
        sz = $urandom_range(0, 9);
        sz = (sz < 3) ? 0 : (sz < 6) ? 1 : (sz < 9) ? 2 : 3;
        a  = 32'($urandom_range(0, 1023));
        if ($urandom_range(0, 3) != 0 && sz < 3) a = a & ~32'(nbytes(2'(sz)) - 1);
        drive_ls(($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)), 2'(sz),
                 1'($urandom_range(0, 1)), a, $urandom);
      end
      cycle();
    end
    drive_if(1'b0, 32'h0);
    drive_ls(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
